wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 12 +
 rtl/wb_result_mux.sv | 24 ++
 rtl/wb_regfile.sv | 84 ++++++++
 tb/tb_wb_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback register file.
// The optional same-cycle bypass is selected by WB_REGFILE_BYPASS_EN.
package wb_regfile_pkg;

  localparam int DATA_W_DEFAULT   = 32;
  localparam int LINK_REG_DEFAULT = 31;
  localparam int REG_ZERO         = 0;
  localparam int NUM_REGS         = 32;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback value select: return address, load data or ALU result.
module wb_result_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              jumplink,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcplus4,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = aluout;
    if (jumplink) begin
      result = pcplus4;
    end else if (memtoreg) begin
      result = rd;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// 31-entry register file with hard-wired zero register, fed by the writeback stage.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int LINK_REG = LINK_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] aluout,
  input  logic [4:0]        writereg,
  input  logic [DATA_W-1:0] pcplus4,
  input  logic              jumplink,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] result,
  output logic              wrote
);

  localparam reg_idx_t LINK_IDX = reg_idx_t'(LINK_REG);
  localparam reg_idx_t ZERO_IDX = reg_idx_t'(REG_ZERO);

  reg_idx_t          wr_addr;
  logic              wr_en;
  logic              wrote_reg;
  logic [DATA_W-1:0] rdata [NUM_REGS];

  wb_result_mux #(
    .DATA_W (DATA_W)
  ) u_result_mux (
    .jumplink (jumplink),
    .memtoreg (memtoreg),
    .rd       (rd),
    .aluout   (aluout),
    .pcplus4  (pcplus4),
    .result   (result)
  );

  assign wr_addr = jumplink ? LINK_IDX : writereg;
  assign wr_en   = regwrite && (wr_addr != ZERO_IDX);

  // Register 0 has no storage; its read slot is tied to zero.
  assign rdata[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_reg <= '0;
      end else if (wr_en && (wr_addr == reg_idx_t'(gi))) begin
        q_reg <= result;
      end
    end

    assign rdata[gi] = q_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrote_reg <= 1'b0;
    end else begin
      wrote_reg <= wr_en;
    end
  end

  assign wrote = wrote_reg;

`ifdef WB_REGFILE_BYPASS_EN
  // wr_en already excludes address 0, so register 0 still reads zero.
  assign rd1 = (wr_en && (ra1 == wr_addr)) ? result : rdata[ra1];
  assign rd2 = (wr_en && (ra2 == wr_addr)) ? result : rdata[ra2];
`else
  assign rd1 = rdata[ra1];
  assign rd2 = rdata[ra2];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (either build of the bypass option).
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        regwrite;
  logic        memtoreg;
  logic [31:0] rd;
  logic [31:0] aluout;
  logic [4:0]  writereg;
  logic [31:0] pcplus4;
  logic        jumplink;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] result;
  logic        wrote;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .regwrite (regwrite),
    .memtoreg (memtoreg),
    .rd       (rd),
    .aluout   (aluout),
    .writereg (writereg),
    .pcplus4  (pcplus4),
    .jumplink (jumplink),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .result   (result),
    .wrote    (wrote)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    regwrite = 1'b0;
    memtoreg = 1'b0;
    jumplink = 1'b0;
    rd       = '0;
    aluout   = '0;
    writereg = '0;
    pcplus4  = '0;
  endtask

  task automatic write_alu(input logic [4:0] idx, input logic [31:0] val);
    idle_inputs();
    regwrite = 1'b1;
    writereg = idx;
    aluout   = val;
    tick();
    idle_inputs();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      #1;
      check($sformatf("%s rd1[%0d]", tag, a), rd1, 32'h0);
      check($sformatf("%s rd2[%0d]", tag, 31 - a), rd2, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ra1   = '0;
    ra2   = '0;
    idle_inputs();

    // Reset state
    #12;
    read_all_zero("reset");
    check("reset wrote", 32'(wrote), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write to r8
    @(negedge clk);
    regwrite = 1'b1;
    aluout   = 32'h1234_5678;
    rd       = 32'h0BAD_0BAD;
    writereg = 5'd8;
    ra1      = 5'd8;
    #1;
    check("alu result", result, 32'h1234_5678);
`ifdef WB_REGFILE_BYPASS_EN
    check("r8 bypass", rd1, 32'h1234_5678);
`else
    check("r8 before edge", rd1, 32'h0);
`endif
    tick();
    idle_inputs();
    check("r8 after", rd1, 32'h1234_5678);
    check("wrote after r8", 32'(wrote), 32'h1);
    tick();
    check("wrote one cycle", 32'(wrote), 32'h0);

    // Jump-and-link goes to r31, r5 untouched
    write_alu(5'd5, 32'h0000_0055);
    regwrite = 1'b1;
    jumplink = 1'b1;
    writereg = 5'd5;
    aluout   = 32'h1111_1111;
    pcplus4  = 32'h0040_0010;
    #1;
    check("jal result", result, 32'h0040_0010);
    tick();
    idle_inputs();
    ra1 = 5'd31;
    ra2 = 5'd5;
    #1;
    check("jal r31", rd1, 32'h0040_0010);
    check("jal r5 kept", rd2, 32'h0000_0055);
    check("jal wrote", 32'(wrote), 32'h1);
    jumplink = 1'b1;
    pcplus4  = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("jal no regwrite r31", rd1, 32'h0040_0010);
    check("jal no regwrite wrote", 32'(wrote), 32'h0);

    // Writes to r0 discarded
    regwrite = 1'b1;
    writereg = 5'd0;
    aluout   = 32'hFFFF_FFFF;
    ra2      = 5'd0;
    #1;
    check("r0 same cycle", rd2, 32'h0);
    tick();
    idle_inputs();
    check("r0 after", rd2, 32'h0);
    check("r0 wrote", 32'(wrote), 32'h0);

    // Load-data write to r9 with both ports reading it
    write_alu(5'd9, 32'h0000_0011);
    regwrite = 1'b1;
    memtoreg = 1'b1;
    rd       = 32'hCAFE_0001;
    aluout   = 32'h0BAD_0BAD;
    writereg = 5'd9;
    ra1      = 5'd9;
    ra2      = 5'd9;
    #1;
    check("load result", result, 32'hCAFE_0001);
`ifdef WB_REGFILE_BYPASS_EN
    check("r9 rd1 bypass", rd1, 32'hCAFE_0001);
    check("r9 rd2 bypass", rd2, 32'hCAFE_0001);
`else
    check("r9 rd1 old", rd1, 32'h0000_0011);
    check("r9 rd2 old", rd2, 32'h0000_0011);
`endif
    tick();
    idle_inputs();
    check("r9 rd1 new", rd1, 32'hCAFE_0001);
    check("r9 rd2 new", rd2, 32'hCAFE_0001);

    // Fill r1..r31 with their index and read back
    for (int i = 1; i < 32; i++) begin
      write_alu(5'(i), 32'(i));
    end
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(32 - i);
      #1;
      check($sformatf("fill rd1[%0d]", i), rd1, 32'(i));
      check($sformatf("fill rd2[%0d]", 32 - i), rd2, 32'(32 - i));
    end

    // Asynchronous reset mid-cycle, while wrote is high
    write_alu(5'd1, 32'h0000_0001);
    check("pre-reset wrote", 32'(wrote), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ra1   = 5'd17;
    #1;
    check("async rd1 r17", rd1, 32'h0);
    check("async wrote", 32'(wrote), 32'h0);
    read_all_zero("async reset");

    // Write during reset dropped, resumes after release
    regwrite = 1'b1;
    writereg = 5'd3;
    aluout   = 32'h0000_0077;
    ra1      = 5'd3;
    tick();
    check("write in reset r3", rd1, 32'h0);
    check("write in reset wrote", 32'(wrote), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle_inputs();
    check("write resumes r3", rd1, 32'h0000_0077);
    check("write resumes wrote", 32'(wrote), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
